// File: rtl/dds_pkg.sv
// Types and constants shared between the DDS transmit path and the I/Q demodulator.
package dds_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DUMP} state_e;

  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_DIV    = 10;

  // Full-precision sum of 2^log2_n products of two data_w-bit signed values cannot overflow.
  function automatic bit acc_width_ok(input int unsigned acc_w,
                                      input int unsigned data_w,
                                      input int unsigned log2_n);
    return acc_w >= 2 * data_w + log2_n;
  endfunction
endpackage

// File: rtl/sample_en_gen.sv
// Free-running sample cadence: SampleEn is high one clock in every DIV.
module sample_en_gen import dds_pkg::*; #(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic Clock,
  input  logic Reset,
  output logic SampleEn
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] clkCnt_q, clkCnt_d;

  always_comb begin
    clkCnt_d = clkCnt_q + CW'(1);
    if (clkCnt_q == CW'(DIV - 1)) clkCnt_d = '0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) clkCnt_q <= '0;
    else       clkCnt_q <= clkCnt_d;
  end

  assign SampleEn = (clkCnt_q == CW'(DIV - 1));
endmodule

// File: rtl/ad2iq_demod.sv
// Quadrature demodulator: multiplies ADC samples by DDS x/y references and
// integrates 2^LOG2_N products, publishing I/Q with a one-cycle Valid pulse.
module ad2iq_demod import dds_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LOG2_N = 12,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DIV    = DEF_DIV
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic signed [DATA_W-1:0] AdcData,
  input  logic signed [DATA_W-1:0] RefX,
  input  logic signed [DATA_W-1:0] RefY,
  input  logic                     Start,
  input  logic                     Continuous,
  output logic signed [ACC_W-1:0]  I,
  output logic signed [ACC_W-1:0]  Q,
  output logic                     Valid,
  output logic                     Busy
);
  localparam int unsigned PW = 2 * DATA_W;

  if (!acc_width_ok(ACC_W, DATA_W, LOG2_N)) begin : g_acc_w_chk
    $error("ad2iq_demod: ACC_W too narrow for DATA_W/LOG2_N");
  end
  if (DIV < 3) begin : g_div_chk
    $error("ad2iq_demod: DIV must be at least 3");
  end

  logic                    SampleEn;
  state_e                  state_q;
  logic signed [PW-1:0]    prodX_q, prodY_q, prodX_d, prodY_d;
  logic                    prodValid_q;
  logic signed [ACC_W-1:0] accI_q, accQ_q, accI_d, accQ_d;
  logic [LOG2_N-1:0]       sampCnt_q;
  logic signed [ACC_W-1:0] I_q, Q_q;
  logic                    Valid_q, Busy_q;

  sample_en_gen #(.DIV(DIV)) u_sample_en (
    .Clock    (Clock),
    .Reset    (Reset),
    .SampleEn (SampleEn)
  );

  always_comb begin
    prodX_d = PW'(AdcData) * PW'(RefX);
    prodY_d = PW'(AdcData) * PW'(RefY);
    accI_d  = accI_q + ACC_W'(prodX_q);
    accQ_d  = accQ_q + ACC_W'(prodY_q);
  end

  // Products are registered one clock before accumulation; DIV >= 3 keeps the
  // accumulate and DUMP cycles clear of the next SampleEn.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      prodX_q     <= '0;
      prodY_q     <= '0;
      prodValid_q <= 1'b0;
      accI_q      <= '0;
      accQ_q      <= '0;
      sampCnt_q   <= '0;
      I_q         <= '0;
      Q_q         <= '0;
      Valid_q     <= 1'b0;
      Busy_q      <= 1'b0;
    end else begin
      Valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q     <= RUN;
            Busy_q      <= 1'b1;
            accI_q      <= '0;
            accQ_q      <= '0;
            sampCnt_q   <= '0;
            prodValid_q <= 1'b0;
          end
        end
        RUN: begin
          prodValid_q <= SampleEn;
          if (SampleEn) begin
            prodX_q <= prodX_d;
            prodY_q <= prodY_d;
          end
          if (prodValid_q) begin
            accI_q    <= accI_d;
            accQ_q    <= accQ_d;
            sampCnt_q <= sampCnt_q + LOG2_N'(1);
            if (sampCnt_q == '1) state_q <= DUMP;
          end
        end
        DUMP: begin
          I_q         <= accI_q;
          Q_q         <= accQ_q;
          Valid_q     <= 1'b1;
          prodValid_q <= 1'b0;
          if (Continuous) begin
            state_q   <= RUN;
            accI_q    <= '0;
            accQ_q    <= '0;
            sampCnt_q <= '0;
          end else begin
            state_q <= IDLE;
            Busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          Busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign I     = I_q;
  assign Q     = Q_q;
  assign Valid = Valid_q;
  assign Busy  = Busy_q;
endmodule
